// File: rtl/noc_pkg.sv
// Shared NoC router definitions: port count, port index type, scheduler state
// encoding and a cyclic port-increment helper.
package noc_pkg;

    localparam int unsigned NUM_PORTS = 5;

    typedef logic [2:0] port_t;

    typedef enum logic [0:0] {
        SCH_IDLE   = 1'b0,
        SCH_LOCKED = 1'b1
    } sched_state_e;

    // p + 1, wrapping to 0 at n
    function automatic port_t next_port(input port_t p, input int unsigned n);
        return (32'(p) + 32'd1 >= n) ? port_t'(0) : port_t'(p + 3'd1);
    endfunction

endpackage

// File: rtl/output_credit_scheduler_if.sv
// Input-buffer <-> output-scheduler bundle.
//   req/dport/is_tail : front-flit status of each input buffer (buffers drive)
//   grant/out_valid/sel : per-cycle transfer decision (scheduler drives)
// master = input-buffer side, slave = scheduler side.
interface output_credit_scheduler_if #(
    parameter int unsigned NUM_PORTS = noc_pkg::NUM_PORTS
) ();

    logic [NUM_PORTS-1:0] req;
    noc_pkg::port_t       dport [0:NUM_PORTS-1];
    logic [NUM_PORTS-1:0] is_tail;
    logic [NUM_PORTS-1:0] grant;
    logic                 out_valid;
    noc_pkg::port_t       sel;

    modport master (output req, dport, is_tail, input grant, out_valid, sel);
    modport slave  (input req, dport, is_tail, output grant, out_valid, sel);

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i,
// searching cyclically.
//   req_i : request vector      ptr_i : starting index
//   gnt_o : one-hot grant       idx_o : granted index    any_o : any request
module rr_pick import noc_pkg::*; #(
    parameter int unsigned N = NUM_PORTS
) (
    input  logic [N-1:0] req_i,
    input  port_t        ptr_i,
    output logic [N-1:0] gnt_o,
    output port_t        idx_o,
    output logic         any_o
);

    logic found;

    // Pass 1 covers [ptr, N-1], pass 2 wraps to [0, ptr-1].
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            if (!found && req_i[i] && (port_t'(i) >= ptr_i)) begin
                found    = 1'b1;
                gnt_o[i] = 1'b1;
                idx_o    = port_t'(i);
            end
        end
        for (int i = 0; i < int'(N); i++) begin
            if (!found && req_i[i]) begin
                found    = 1'b1;
                gnt_o[i] = 1'b1;
                idx_o    = port_t'(i);
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/output_credit_scheduler.sv
// Per-output-port scheduler: round-robin head arbitration among input buffers
// targeting this port, wormhole lock from head to tail, downstream credit gating.
// Optional credit overflow check enabled by macro OCS_CREDIT_CHECK_EN.
//   clk, rst    : clock, asynchronous active-low reset
//   bus (slave) : req/dport/is_tail in, grant/out_valid/sel out (combinational)
//   credit_in   : downstream freed one slot
//   locked      : packet in progress owns the port
//   credits     : current downstream credit count
//   credit_err  : sticky credit overflow flag (0 when check not built)
module output_credit_scheduler #(
    parameter  int unsigned PORT_ADDRESS = 0,
    parameter  int unsigned NUM_PORTS    = noc_pkg::NUM_PORTS,
    parameter  int unsigned CREDIT_DEPTH = 4,
    localparam int unsigned CW           = $clog2(CREDIT_DEPTH + 1)
) (
    input  logic                             clk,
    input  logic                             rst,
    output_credit_scheduler_if.slave         bus,
    input  logic                             credit_in,
    output logic                             locked,
    output logic [CW-1:0]                    credits,
    output logic                             credit_err
);

    localparam logic [0:0]     ST_IDLE   = 1'(noc_pkg::SCH_IDLE);
    localparam logic [0:0]     ST_LOCKED = 1'(noc_pkg::SCH_LOCKED);
    localparam noc_pkg::port_t MY_PORT   = noc_pkg::port_t'(PORT_ADDRESS);
    localparam logic [CW-1:0]  CRED_MAX  = CW'(CREDIT_DEPTH);

    logic [0:0]           state_q, state_d;
    noc_pkg::port_t       owner_q, owner_d;
    noc_pkg::port_t       rr_ptr_q, rr_ptr_d;
    noc_pkg::port_t       sel_q, gidx_c;
    logic [CW-1:0]        credits_q, credits_d;
    logic [NUM_PORTS-1:0] eligible_c, pick_gnt_c, grant_c;
    noc_pkg::port_t       pick_idx_c;
    logic                 pick_any_c;
    logic                 credit_ok_c;

    // Buffers whose front flit targets this port.
    always_comb begin
        eligible_c = '0;
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            eligible_c[i] = bus.req[i] && (bus.dport[i] == MY_PORT);
        end
    end

    rr_pick #(.N(NUM_PORTS)) u_pick (
        .req_i (eligible_c),
        .ptr_i (rr_ptr_q),
        .gnt_o (pick_gnt_c),
        .idx_o (pick_idx_c),
        .any_o (pick_any_c)
    );

    // Holding reset also blocks grants, since the registers already show reset values.
    assign credit_ok_c = rst && (credits_q != '0);

    // Next-state and grant decision; gidx_c falls back to the last granted index.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        grant_c  = '0;
        gidx_c   = sel_q;
        case (state_q)
            ST_IDLE: begin
                if (credit_ok_c && pick_any_c) begin
                    grant_c  = pick_gnt_c;
                    gidx_c   = pick_idx_c;
                    rr_ptr_d = noc_pkg::next_port(pick_idx_c, NUM_PORTS);
                    if (!bus.is_tail[pick_idx_c]) begin
                        state_d = ST_LOCKED;
                        owner_d = pick_idx_c;
                    end
                end
            end
            default: begin
                // Body flits carry no routing info, so dport is ignored here.
                if (credit_ok_c && bus.req[owner_q]) begin
                    grant_c = NUM_PORTS'(1) << owner_q;
                    gidx_c  = owner_q;
                    if (bus.is_tail[owner_q]) begin
                        state_d = ST_IDLE;
                    end
                end
            end
        endcase
    end

    // A grant and a returned credit in the same cycle cancel out.
    always_comb begin
        credits_d = credits_q;
        if ((|grant_c) && !credit_in) begin
            credits_d = credits_q - CW'(1);
        end else if (!(|grant_c) && credit_in && (credits_q != CRED_MAX)) begin
            credits_d = credits_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            owner_q   <= '0;
            rr_ptr_q  <= '0;
            sel_q     <= '0;
            credits_q <= CRED_MAX;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_ptr_q  <= rr_ptr_d;
            sel_q     <= gidx_c;
            credits_q <= credits_d;
        end
    end

`ifdef OCS_CREDIT_CHECK_EN
    logic err_q, err_d;

    // A credit returned while already full (and not consumed) is an overflow.
    assign err_d = err_q | (credit_in && !(|grant_c) && (credits_q == CRED_MAX));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign credit_err = err_q;
`else
    assign credit_err = 1'b0;
`endif

    assign bus.grant     = grant_c;
    assign bus.out_valid = |grant_c;
    assign bus.sel       = gidx_c;
    assign locked        = (state_q == ST_LOCKED);
    assign credits       = credits_q;

endmodule

// File: doc/output_credit_scheduler.md
# output_credit_scheduler

Per-output-port scheduler for the 5-port wormhole router. Sits between the input buffers and one crossbar output: it arbitrates round-robin among the buffers whose front flit targets this port, holds the port for a whole packet from head to tail, and gates every transfer on downstream credits. The allocator instantiates one per output port; the allocator ORs `grant` bits per input buffer.

## Interface
- `PORT_ADDRESS`, 0: output port served by this instance, 0..4.
- `NUM_PORTS`, 5: number of input buffers (requesters).
- `CREDIT_DEPTH`, 4: downstream buffer depth in flits, 1..15.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `req`  in  NUM_PORTS  buffer i holds a valid front flit.
- `dport`  in  3 x NUM_PORTS (unpacked [0:NUM_PORTS-1])  destination port of buffer i's front flit.
- `is_tail`  in  NUM_PORTS  buffer i's front flit is a tail (single-flit packet = head+tail).
- `credit_in`  in  1  downstream freed one slot this cycle.
- `grant`  out  NUM_PORTS  one-hot or zero; flit of buffer i crosses this cycle.
- `out_valid`  out  1  `|grant`.
- `sel`  out  3  crossbar select: granted index, else last granted index.
- `locked`  out  1  port held by a packet in progress.
- `credits`  out  $clog2(CREDIT_DEPTH+1)  current downstream credit count.
- `credit_err`  out  1  sticky credit protocol error (see Configuration).

## Operation
- eligible[i] = req[i] && dport[i] == PORT_ADDRESS.
- State machine: IDLE, LOCKED (owner index held in a register).
- IDLE: if credits > 0 and any eligible, grant the first eligible index at or after `rr_ptr`, cyclically. Update `rr_ptr` <= granted+1 mod NUM_PORTS. If granted flit not tail -> LOCKED, owner <= granted; if tail -> stay IDLE.
- LOCKED: only owner considered; grant when req[owner] && credits > 0, dport ignored (body flits). Other requesters get no grant. Granting a tail -> IDLE. `rr_ptr` not updated.
- Credits: decrement on any grant, increment on `credit_in`; both in one cycle -> unchanged. Never grant at 0. `credit_in` at CREDIT_DEPTH saturates (count unchanged).
- `sel` register loads granted index on every grant; combinational `sel` output equals granted index in a grant cycle, else register.
- `locked` = (state == LOCKED).

## Timing
- `grant`, `out_valid`, `sel` combinational from current state and inputs (zero-cycle decision); buffer dequeues and crossbar passes the flit in the same cycle.
- Credit change visible on `credits` the cycle after the event; `credit_in` arriving while credits == 0 enables a grant one cycle later, not the same cycle.
- Back-to-back packets: tail grant in cycle N, next head grant (any requester) possible in cycle N+1.
- Reset values: state IDLE, `locked` 0, `rr_ptr` 0, `sel` 0, `credits` CREDIT_DEPTH, `credit_err` 0, `grant` 0 while `rst` low.
- Reset mid-packet: lock dropped, credits restored to CREDIT_DEPTH; no grant until `rst` deasserts.

## Configuration
- `OCS_CREDIT_CHECK_EN` defined: `credit_err` set on `credit_in` while credits == CREDIT_DEPTH (without simultaneous grant), and on req[owner] with is_tail/dport change before tail impossible to detect -> only the overflow check; sticky until reset.
- Undefined: no check logic; `credit_err` tied 0.

## Structure
- Shared package `noc_pkg`: `NUM_PORTS` constant, `port_t` (logic [2:0]), scheduler state enum.
- One sub-module `rr_pick`: combinational round-robin picker (request vector + pointer -> one-hot grant + index).

## Test plan
- Reset, buffers 1 and 3 both req dport=PORT_ADDRESS single-flit, credits 4 -> grant 1 in cycle 0, grant 3 in cycle 1, `rr_ptr` 4.
- Buffer 2 sends 3-flit packet while buffer 0 requests same port -> grant 2 for 3 consecutive cycles, `locked` 1 until tail, buffer 0 granted cycle after tail.
- CREDIT_DEPTH=4, 6 flits queued, no `credit_in` -> 4 grants, then `credits`=0 and grant 0; pulse `credit_in` -> one grant the following cycle.
- Grant and `credit_in` same cycle at credits=2 -> credits stays 2.
- `rst` low mid-packet (locked, credits 1) -> locked 0, credits 4, grant 0; after release new head accepted from `rr_ptr` 0.
- With `OCS_CREDIT_CHECK_EN`, `credit_in` at credits=4 idle -> `credit_err` 1 and held; without macro stays 0.
